// File: rtl/mult_sequencer_pkg.sv
// Shared types and defaults for the Booth multiplier sequencer.
// State encoding plus default operand width and radix-4 step count.
package mult_sequencer_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ITERATIONS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the Booth sequencer.
// Clear wins over enable; otherwise the count holds.
module iter_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for an external radix-4 Booth multiplier datapath.
// Latches operands, steps the iteration count and captures the product.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ITERATIONS = DEF_ITERATIONS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [WIDTH-1:0] mult_product,
  input  logic             mult_overflow,
  output logic [WIDTH-1:0] mult_multiplicand,
  output logic [WIDTH-1:0] mult_multiplier,
  output logic [31:0]      mult_counter,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [31:0] ITER_LAST = 32'(ITERATIONS);

  state_t state_q;
  state_t state_d;
  logic   clear;
  logic   enable;
  logic   capture;

  iter_counter u_iter_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .enable  (enable),
    .count   (mult_counter)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A start request overrides every state, including the capture step.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    enable  = 1'b0;
    capture = 1'b0;
    if (ctrl_mult) begin
      state_d = RUN;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (mult_counter < ITER_LAST) begin
            enable = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mult_multiplicand <= '0;
      mult_multiplier   <= '0;
    end else if (ctrl_mult) begin
      mult_multiplicand <= data_operandA;
      mult_multiplier   <= data_operandB;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (capture) begin
      data_result    <= mult_product;
      data_exception <= mult_overflow;
    end
  end

  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter ITERATIONS, default 16, giving the radix-4 Booth step count for WIDTH bits.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ctrl_mult  input  1  start request, sampled each rising edge.
REQ-006 data_operandA  input  WIDTH  multiplicand, sampled when ctrl_mult=1.
REQ-007 data_operandB  input  WIDTH  multiplier, sampled when ctrl_mult=1.
REQ-008 mult_product  input  WIDTH  product returned by the Booth datapath.
REQ-009 mult_overflow  input  1  overflow flag returned by the Booth datapath.
REQ-010 mult_multiplicand  output  WIDTH  latched operand A, driven to the datapath.
REQ-011 mult_multiplier  output  WIDTH  latched operand B, driven to the datapath.
REQ-012 mult_counter  output  32  iteration count; value 0 commands the datapath to load its initial product.
REQ-013 data_result  output  WIDTH  captured product.
REQ-014 data_exception  output  1  captured overflow.
REQ-015 data_resultRDY  output  1  one-cycle pulse marking a new result.
REQ-016 busy  output  1  high in RUN.

Function
REQ-017 The block SHALL implement the states IDLE, RUN and DONE.
REQ-018 In any state, ctrl_mult=1 at an edge SHALL latch both operands, clear mult_counter to 0 and enter RUN.
REQ-019 In RUN with mult_counter < ITERATIONS, each edge SHALL increment mult_counter by 1.
REQ-020 In RUN with mult_counter = ITERATIONS and ctrl_mult=0, the edge SHALL capture mult_product into data_result and mult_overflow into data_exception, and enter DONE.
REQ-021 data_resultRDY SHALL be 1 exactly while in DONE, i.e. for one cycle, first asserted ITERATIONS+1 edges after the start edge (17 for defaults).
REQ-022 DONE SHALL go to IDLE on the next edge unless ctrl_mult=1, in which case REQ-018 applies.
REQ-023 mult_counter SHALL hold its value in DONE and IDLE.
REQ-024 mult_multiplicand and mult_multiplier SHALL change only on a start edge and stay stable throughout RUN.
REQ-025 data_result and data_exception SHALL hold their values until the next capture.
REQ-026 A start during RUN SHALL abort the current operation: no capture and no data_resultRDY for the aborted operation, and the new operation's latency counts from the new start edge.
REQ-027 The start edge SHALL take priority over the capture edge when both coincide.
REQ-028 busy SHALL equal (state = RUN).

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for clk, force state=IDLE and set mult_counter, mult_multiplicand, mult_multiplier, data_result, data_exception, data_resultRDY and busy to 0.
REQ-030 Reset asserted mid-RUN SHALL discard the operation, and no data_resultRDY SHALL follow.
REQ-031 After reset_n rises, the first action SHALL be the first edge with ctrl_mult=1.

Structure
REQ-032 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the default ITERATIONS and WIDTH constants.
REQ-033 The counter SHALL be a sub-module iter_counter with clear, enable and hold functions and async active-low reset; all other logic is in mult_sequencer.

Verification
REQ-034 Scenario 1: A=7, B=6, with the datapath model returning 42 -> data_resultRDY high for 1 cycle, 17 edges after the start edge; data_result=42; data_exception=0.
REQ-035 Scenario 2: A=-3, B=5 -> data_result=0xFFFFFFF1 and data_exception=0; mult_multiplicand=0xFFFFFFFD throughout RUN.
REQ-036 Scenario 3: A=0x00010000, B=0x00010000, with mult_overflow=1 -> data_exception=1; data_exception holds until the next capture.
REQ-037 Scenario 4: start A=2, B=3; restart at counter=8 with A=4, B=5 -> exactly one data_resultRDY, 17 edges after the second start, with product 20.
REQ-038 Scenario 5: reset_n low at counter=10 -> all outputs 0 immediately, before the next clk edge; no data_resultRDY follows; a later start A=1, B=1 completes normally.
REQ-039 Scenario 6: ctrl_mult held high in DONE -> the new operation starts, mult_counter returns to 0, and the previous data_resultRDY pulse is still exactly 1 cycle.
